// File: rtl/ov7670_pkg.sv
// Shared state encoding and table constants for the OV7670 configuration path.
package ov7670_pkg;

  typedef enum logic [3:0] {
    BOOT_WAIT,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_BUSY_LO,
    GAP,
    DELAY,
    INC,
    DONE,
    ERROR
  } cfgState_t;

  // Table markers: anything else in the table is a {subaddress, data} write.
  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  // SCCB write address of the camera and the 3-phase write mode code.
  localparam logic [7:0] OV7670_WR_ADDR = 8'h42;
  localparam logic [1:0] SCCB_MODE_WR3  = 2'b00;

endpackage

// File: rtl/ov7670_config_rom.sv
// Register table for the OV7670: RGB565 output with matrix, window and
// gamma setup. Each entry is {subaddress, data} or one of the table markers.
module ov7670_config_rom
  import ov7670_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 128
) (
  input  logic                         clk,
  input  logic [$clog2(ROM_DEPTH)-1:0] i_addr,
  output logic [15:0]                  o_entry
);

  logic [31:0] w_addr;
  logic [15:0] w_entry;

  assign w_addr = 32'(i_addr);

  // Table lookup; unused addresses read back as end-of-table.
  always_comb begin
    w_entry = CFG_END;
    case (w_addr)
      // Soft reset, then let the sensor settle before anything else.
      32'd0  : w_entry = 16'h1280;
      32'd1  : w_entry = CFG_DELAY;
      // Output format and clocking.
      32'd2  : w_entry = 16'h1204;
      32'd3  : w_entry = 16'h1101;
      32'd4  : w_entry = 16'h0C00;
      32'd5  : w_entry = 16'h3E00;
      32'd6  : w_entry = 16'h8C00;
      32'd7  : w_entry = 16'h0400;
      32'd8  : w_entry = 16'h4010;
      32'd9  : w_entry = 16'h3A04;
      32'd10 : w_entry = 16'h1438;
      // Colour matrix.
      32'd11 : w_entry = 16'h4FB3;
      32'd12 : w_entry = 16'h50B3;
      32'd13 : w_entry = 16'h5100;
      32'd14 : w_entry = 16'h523D;
      32'd15 : w_entry = 16'h53A7;
      32'd16 : w_entry = 16'h54E4;
      32'd17 : w_entry = 16'h589E;
      32'd18 : w_entry = 16'h3DC0;
      // Frame window and sync.
      32'd19 : w_entry = 16'h1714;
      32'd20 : w_entry = 16'h1802;
      32'd21 : w_entry = 16'h3280;
      32'd22 : w_entry = 16'h1903;
      32'd23 : w_entry = 16'h1A7B;
      32'd24 : w_entry = 16'h030A;
      32'd25 : w_entry = 16'h0F41;
      32'd26 : w_entry = 16'h1E00;
      32'd27 : w_entry = 16'h330B;
      32'd28 : w_entry = 16'h3C78;
      32'd29 : w_entry = 16'h6900;
      32'd30 : w_entry = 16'h7400;
      // Reserved magic values and black level calibration.
      32'd31 : w_entry = 16'hB084;
      32'd32 : w_entry = 16'hB10C;
      32'd33 : w_entry = 16'hB20E;
      32'd34 : w_entry = 16'hB380;
      // Gamma curve.
      32'd35 : w_entry = 16'h7A20;
      32'd36 : w_entry = 16'h7B10;
      32'd37 : w_entry = 16'h7C1E;
      32'd38 : w_entry = 16'h7D35;
      32'd39 : w_entry = CFG_END;
      default: w_entry = CFG_END;
    endcase
  end

  // Registered read port, so an entry is valid one cycle after its address.
  always_ff @(posedge clk) begin
    o_entry <= w_entry;
  end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register table after power-up and hands each entry to
// the SCCB master as a 3-phase write, with delay/end markers and done/error
// status for the top level.
module ov7670_config_sequencer
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned BOOT_WAIT_CYCLES = CLK_HZ / 1000,
  parameter int unsigned DELAY_CYCLES     = CLK_HZ / 100,
  parameter int unsigned GAP_CYCLES       = 256,
  parameter int unsigned USHER_TIMEOUT    = 1024,
  parameter int unsigned ROM_DEPTH        = 128,
  parameter logic [7:0]  DEVICE_ADDR      = OV7670_WR_ADDR
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_sccb_busy,
  output logic                         o_usher,
  output logic [7:0]                   o_address,
  output logic [7:0]                   o_subaddress,
  output logic [7:0]                   o_data,
  output logic [1:0]                   o_mode,
  output logic                         o_done,
  output logic                         o_error,
  output logic [$clog2(ROM_DEPTH)-1:0] o_index
);

  localparam int unsigned AW = $clog2(ROM_DEPTH);

  localparam logic [31:0]   BOOT_LAST    = 32'(BOOT_WAIT_CYCLES - 1);
  localparam logic [31:0]   DELAY_LAST   = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(USHER_TIMEOUT - 1);
  localparam logic [AW-1:0] INDEX_LAST   = AW'(ROM_DEPTH - 1);

  cfgState_t     r_state;
  logic [31:0]   r_count;
  logic [AW-1:0] r_index;
  logic          r_usher;
  logic [7:0]    r_subaddress;
  logic [7:0]    r_data;
  logic          r_done;
  logic          r_error;
  logic [15:0]   w_entry;

  // The table index drives the ROM directly; it is stable through FETCH,
  // so the entry is ready when DECODE looks at it.
  ov7670_config_rom #(
    .ROM_DEPTH(ROM_DEPTH)
  ) u_rom (
    .clk    (clk),
    .i_addr (r_index),
    .o_entry(w_entry)
  );

  assign o_address    = DEVICE_ADDR;
  assign o_mode       = SCCB_MODE_WR3;
  assign o_usher      = r_usher;
  assign o_subaddress = r_subaddress;
  assign o_data       = r_data;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_index      = r_index;

  // Sequencer FSM: every state entry clears the counter, and usher is held
  // (not pulsed) until the SCCB master reports busy or the timeout expires.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state      <= BOOT_WAIT;
      r_count      <= '0;
      r_index      <= '0;
      r_usher      <= 1'b0;
      r_subaddress <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        BOOT_WAIT: begin
          if (r_count == BOOT_LAST) begin
            r_state <= FETCH;
            r_count <= '0;
            r_index <= '0;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end

        FETCH: begin
          r_state <= DECODE;
          r_count <= '0;
        end

        DECODE: begin
          r_count <= '0;
          if (w_entry == CFG_END) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_entry == CFG_DELAY) begin
            r_state <= DELAY;
          end else begin
            r_subaddress <= w_entry[15:8];
            r_data       <= w_entry[7:0];
            r_usher      <= 1'b1;
            r_state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (i_sccb_busy) begin
            r_usher <= 1'b0;
            r_state <= WAIT_BUSY_LO;
            r_count <= '0;
          end else if (r_count == TIMEOUT_LAST) begin
            r_usher <= 1'b0;
            r_error <= 1'b1;
            r_state <= ERROR;
            r_count <= '0;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end

        WAIT_BUSY_LO: begin
          if (!i_sccb_busy) begin
            r_state <= GAP;
            r_count <= '0;
          end
        end

        GAP: begin
          if (r_count == GAP_LAST) begin
            r_state <= INC;
            r_count <= '0;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end

        DELAY: begin
          if (r_count == DELAY_LAST) begin
            r_state <= INC;
            r_count <= '0;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end

        INC: begin
          r_count <= '0;
          if (r_index == INDEX_LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_index <= r_index + AW'(1);
            r_state <= FETCH;
          end
        end

        DONE: begin
          if (i_start) begin
            r_done  <= 1'b0;
            r_index <= '0;
            r_count <= '0;
            r_state <= FETCH;
          end
        end

        ERROR: begin
          r_usher <= 1'b0;
          if (i_start) begin
            r_error <= 1'b0;
            r_index <= '0;
            r_count <= '0;
            r_state <= FETCH;
          end
        end

        default: begin
          r_state <= BOOT_WAIT;
          r_count <= '0;
          r_usher <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for the OV7670 configuration sequencer: a behavioural SCCB master
// answers usher, and a scoreboard holds the writes each run must produce.
module tb_ov7670_config_sequencer;

  localparam int BOOT      = 10;
  localparam int DELAY     = 20;
  localparam int GAP       = 4;
  localparam int TIMEOUT   = 16;
  localparam int DEPTH     = 128;
  localparam int AW        = $clog2(DEPTH);
  localparam int LEAD      = 2;
  localparam int BUSY_LEN  = 50;
  localparam int TABLE_LEN = 40;
  localparam int NORMAL_SPACING = LEAD + 1 + BUSY_LEN + GAP + 3;

  typedef struct {
    logic [15:0] entry;
    int          spacing;
  } expWrite_t;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_sccb_busy;
  logic          o_usher;
  logic [7:0]    o_address;
  logic [7:0]    o_subaddress;
  logic [7:0]    o_data;
  logic [1:0]    o_mode;
  logic          o_done;
  logic          o_error;
  logic [AW-1:0] o_index;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] expTable [0:TABLE_LEN-1] = '{
    16'h1280, 16'hFFF0, 16'h1204, 16'h1101, 16'h0C00, 16'h3E00, 16'h8C00, 16'h0400,
    16'h4010, 16'h3A04, 16'h1438, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7,
    16'h54E4, 16'h589E, 16'h3DC0, 16'h1714, 16'h1802, 16'h3280, 16'h1903, 16'h1A7B,
    16'h030A, 16'h0F41, 16'h1E00, 16'h330B, 16'h3C78, 16'h6900, 16'h7400, 16'hB084,
    16'hB10C, 16'hB20E, 16'hB380, 16'h7A20, 16'h7B10, 16'h7C1E, 16'h7D35, 16'hFFFF
  };

  expWrite_t expQ [$];
  expWrite_t monWrite;

  logic sccbBusy    = 1'b0;
  logic modelEnable = 1'b1;
  logic busyRose    = 1'b0;
  int   leadTimer   = 0;
  int   busyTimer   = 0;
  logic prevUsher   = 1'b0;
  int   sinceRise   = 0;
  int   endIndex;
  int   thirdIndex;
  int   highCycles;

  assign i_sccb_busy = sccbBusy;

  ov7670_config_sequencer #(
    .CLK_HZ          (100_000_000),
    .BOOT_WAIT_CYCLES(BOOT),
    .DELAY_CYCLES    (DELAY),
    .GAP_CYCLES      (GAP),
    .USHER_TIMEOUT   (TIMEOUT),
    .ROM_DEPTH       (DEPTH),
    .DEVICE_ADDR     (8'h42)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_sccb_busy (i_sccb_busy),
    .o_usher     (o_usher),
    .o_address   (o_address),
    .o_subaddress(o_subaddress),
    .o_data      (o_data),
    .o_mode      (o_mode),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_index     (o_index)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive reset/start for one cycle; start always returns low afterwards.
  task automatic applyStimulus(input logic resetVal, input logic startVal);
    i_reset = resetVal;
    i_start = startVal;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Queue every write of one table pass with its expected rise-to-rise spacing.
  task automatic pushRun();
    int delays = 0;
    logic first = 1'b1;
    for (int i = 0; i < TABLE_LEN; i++) begin
      if (expTable[i] == 16'hFFFF) break;
      if (expTable[i] == 16'hFFF0) begin
        delays++;
      end else begin
        expQ.push_back('{entry: expTable[i],
                         spacing: first ? -1 : NORMAL_SPACING + delays * (DELAY + 3)});
        first  = 1'b0;
        delays = 0;
      end
    end
  endtask

  task automatic pushFirst();
    expQ.push_back('{entry: expTable[0], spacing: -1});
  endtask

  task automatic checkResetState();
    checkOutput("rstUsher", 32'(o_usher), 32'd0);
    checkOutput("rstSub", 32'(o_subaddress), 32'd0);
    checkOutput("rstData", 32'(o_data), 32'd0);
    checkOutput("rstDone", 32'(o_done), 32'd0);
    checkOutput("rstError", 32'(o_error), 32'd0);
    checkOutput("rstIndex", 32'(o_index), 32'd0);
    checkOutput("rstAddr", 32'(o_address), 32'h42);
    checkOutput("rstMode", 32'(o_mode), 32'd0);
  endtask

  // Reset is released at a negedge; BOOT counts finish on the BOOT-th edge,
  // then FETCH and DECODE take one edge each before usher is raised.
  task automatic releaseAndCheckBoot();
    i_reset = 1'b0;
    repeat (BOOT + 1) @(negedge clk);
    checkOutput("bootUsherLow", 32'(o_usher), 32'd0);
    @(negedge clk);
    checkOutput("bootUsherHigh", 32'(o_usher), 32'd1);
    checkOutput("bootIndex", 32'(o_index), 32'd0);
  endtask

  task automatic waitUsherRise(input string tag);
    logic seen;
    logic prev;
    seen = 1'b0;
    prev = o_usher;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (o_usher && !prev) seen = 1'b1;
      prev = o_usher;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 5000 && !o_done; i++) @(negedge clk);
    checkOutput("doneReached", 32'(o_done), 32'd1);
  endtask

  task automatic checkRunEnd();
    checkOutput("endIndex", 32'(o_index), 32'(endIndex));
    checkOutput("endError", 32'(o_error), 32'd0);
    checkOutput("endUsher", 32'(o_usher), 32'd0);
    checkOutput("endQueueEmpty", 32'(expQ.size()), 32'd0);
  endtask

  // Behavioural SCCB master: busy rises LEAD cycles after usher is seen and
  // stays high for BUSY_LEN cycles; usher must be gone one cycle after busy.
  always @(negedge clk) begin
    if (busyRose) begin
      checkOutput("usherDropAfterBusy", 32'(o_usher), 32'd0);
      busyRose = 1'b0;
    end
    if (busyTimer > 0) begin
      busyTimer--;
      if (busyTimer == 0) sccbBusy = 1'b0;
    end else if (leadTimer > 0) begin
      leadTimer--;
      if (leadTimer == 0) begin
        sccbBusy  = 1'b1;
        busyTimer = BUSY_LEN;
        busyRose  = 1'b1;
      end
    end else if (modelEnable && o_usher) begin
      leadTimer = LEAD;
    end
  end

  // Scoreboard: each usher rise consumes the oldest expected write.
  always @(negedge clk) begin
    sinceRise++;
    if (o_usher && !prevUsher) begin
      checkOutput("usherQueued", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        monWrite = expQ.pop_front();
        checkOutput("writeSub", 32'(o_subaddress), 32'(monWrite.entry[15:8]));
        checkOutput("writeData", 32'(o_data), 32'(monWrite.entry[7:0]));
        checkOutput("writeAddr", 32'(o_address), 32'h42);
        checkOutput("writeMode", 32'(o_mode), 32'd0);
        if (monWrite.spacing >= 0)
          checkOutput("writeSpacing", sinceRise, monWrite.spacing);
      end
      sinceRise = 0;
    end
    prevUsher = o_usher;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    endIndex   = 0;
    thirdIndex = 0;
    for (int i = 0, w = 0; i < TABLE_LEN; i++) begin
      if (expTable[i] == 16'hFFFF) begin
        endIndex = i;
        break;
      end
      if (expTable[i] != 16'hFFF0) begin
        w++;
        if (w == 3) thirdIndex = i;
      end
    end

    i_reset = 1'b1;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkResetState();

    $display("[TB] boot and full table");
    pushRun();
    releaseAndCheckBoot();
    checkOutput("firstSub", 32'(o_subaddress), 32'h12);
    checkOutput("firstData", 32'(o_data), 32'h80);
    waitDone();
    checkRunEnd();
    repeat (200) @(negedge clk);
    checkOutput("doneHolds", 32'(o_done), 32'd1);
    checkOutput("quietAfterDone", 32'(expQ.size()), 32'd0);

    $display("[TB] restart from done, start ignored mid-sequence");
    pushRun();
    applyStimulus(1'b0, 1'b1);
    checkOutput("restartDoneClr", 32'(o_done), 32'd0);
    checkOutput("restartIndex", 32'(o_index), 32'd0);
    @(negedge clk);
    checkOutput("restartUsherLow", 32'(o_usher), 32'd0);
    @(negedge clk);
    checkOutput("restartUsherHigh", 32'(o_usher), 32'd1);
    repeat (4) waitUsherRise("midRise");
    applyStimulus(1'b0, 1'b1);
    checkOutput("midStartNoDone", 32'(o_done), 32'd0);
    waitDone();
    checkRunEnd();

    $display("[TB] reset during a write");
    pushRun();
    applyStimulus(1'b0, 1'b1);
    repeat (3) waitUsherRise("preResetRise");
    for (int i = 0; i < 200 && !(sccbBusy && !o_usher); i++) @(negedge clk);
    checkOutput("wbIndex", 32'(o_index), 32'(thirdIndex));
    applyStimulus(1'b1, 1'b0);
    expQ.delete();
    checkOutput("midRstUsher", 32'(o_usher), 32'd0);
    checkOutput("midRstIndex", 32'(o_index), 32'd0);
    checkOutput("midRstSub", 32'(o_subaddress), 32'd0);
    repeat (60) @(negedge clk);
    checkResetState();
    pushRun();
    releaseAndCheckBoot();
    waitDone();
    checkRunEnd();

    $display("[TB] usher timeout");
    modelEnable = 1'b0;
    pushFirst();
    applyStimulus(1'b0, 1'b1);
    waitUsherRise("toRise");
    highCycles = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_usher) break;
      highCycles++;
    end
    checkOutput("toUsherCycles", highCycles, TIMEOUT);
    checkOutput("toError", 32'(o_error), 32'd1);
    checkOutput("toDone", 32'(o_done), 32'd0);
    checkOutput("toSubHeld", 32'(o_subaddress), 32'h12);
    checkOutput("toDataHeld", 32'(o_data), 32'h80);
    repeat (10) @(negedge clk);
    checkOutput("toErrorHolds", 32'(o_error), 32'd1);
    checkOutput("toUsherLow", 32'(o_usher), 32'd0);

    pushFirst();
    applyStimulus(1'b0, 1'b1);
    checkOutput("errClr", 32'(o_error), 32'd0);
    checkOutput("errRestartIndex", 32'(o_index), 32'd0);
    waitUsherRise("errRestartRise");
    for (int i = 0; i < 100 && !o_error; i++) @(negedge clk);
    checkOutput("errAgain", 32'(o_error), 32'd1);
    checkOutput("errQueueEmpty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
- Upstream driver for the SCCB master.
- After reset, waits for the camera power-up interval, then walks a register table of {subaddress, data} pairs. Each entry becomes one 3-phase SCCB write to the OV7670.
- Supports in-table delay and end markers, and reports done or error to the top level.
- Can be re-triggered to reload the camera configuration.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; documentation only.
- BOOT_WAIT_CYCLES, 100_000, cycles to wait after reset before the first write (1 ms at 100 MHz).
- DELAY_CYCLES, 1_000_000, cycles consumed by one delay-marker entry (10 ms).
- GAP_CYCLES, 256, idle cycles between the end of one write and the next usher.
- USHER_TIMEOUT, 1024, maximum cycles o_usher is held waiting for busy to rise.
- ROM_DEPTH, 128, number of table entries; address width is $clog2(ROM_DEPTH).
- DEVICE_ADDR, 8'h42, OV7670 write address.

Ports:
- clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  single-cycle pulse: restart the table from entry 0. Honoured only in DONE or ERROR.
- i_sccb_busy  in  1  o_busy of the SCCB master
- o_usher  out  1  to SCCB i_usher
- o_address  out  8  to SCCB i_address; constant DEVICE_ADDR
- o_subaddress  out  8  to SCCB i_subaddress
- o_data  out  8  to SCCB i_data
- o_mode  out  2  to SCCB i_mode; constant 2'b00 (3-phase write)
- o_done  out  1  high while in DONE
- o_error  out  1  high while in ERROR
- o_index  out  $clog2(ROM_DEPTH)  current table index, for debug

Behaviour:
- Reset values:
  - o_usher=0, o_subaddress=0, o_data=0, o_done=0, o_error=0, o_index=0.
  - o_address=DEVICE_ADDR, o_mode=2'b00.
  - State=BOOT_WAIT, counter=0.
- Reset asserted in any state, including mid-write, returns to the reset state on the next edge. o_usher drops immediately. The SCCB master finishes any in-flight transaction on its own.
- Table entries are 16 bits, {subaddress[15:8], data[7:0]}, read synchronously with 1-cycle latency.
- Table markers:
  - 16'hFFFF = end of table.
  - 16'hFFF0 = delay.
  - Any other value = register write.
- States:
  - BOOT_WAIT: count to BOOT_WAIT_CYCLES-1, then go to FETCH with index 0.
  - FETCH: present index to the ROM. Next cycle go to DECODE.
  - DECODE:
    - Entry FFFF → DONE.
    - Entry FFF0 → DELAY, counter cleared.
    - Otherwise latch subaddress and data onto the outputs and go to ISSUE.
  - ISSUE: o_usher=1, counter increments each cycle.
    - i_sccb_busy=1 → WAIT_BUSY_LO and o_usher=0 next cycle.
    - Counter reaches USHER_TIMEOUT-1 with busy still 0 → ERROR.
    - o_usher is held rather than pulsed because the SCCB master samples usher through a register while idle.
  - WAIT_BUSY_LO: i_sccb_busy=0 → GAP, counter cleared. There is no timeout here; the SCCB transaction length is bounded.
  - GAP: count GAP_CYCLES-1 → INC.
  - DELAY: count DELAY_CYCLES-1 → INC.
  - INC:
    - If index==ROM_DEPTH-1 → DONE (running off the end counts as end of table).
    - Else index+1 → FETCH.
    - Index never wraps.
  - DONE: o_done=1.
    - i_start → BOOT_WAIT skipped; go to FETCH with index 0 and o_done cleared the same edge.
  - ERROR: o_error=1, o_usher=0. Outputs stay latched at the failing entry.
    - i_start → FETCH with index 0 and o_error cleared.
- i_start in any other state is ignored.
- Counters are 32-bit unsigned, cleared on every state entry. Comparisons are equality against PARAM-1.
- o_subaddress and o_data stay stable from DECODE through the end of WAIT_BUSY_LO.
- Per-write latency: DECODE→usher is 1 cycle. Write-to-write spacing is the SCCB transaction length plus GAP_CYCLES plus 3.

Decomposition:
- Shared package ov7670_pkg holds:
  - the state enum (BOOT_WAIT, FETCH, DECODE, ISSUE, WAIT_BUSY_LO, GAP, DELAY, INC, DONE, ERROR);
  - the marker constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0;
  - OV7670_WR_ADDR=8'h42 and SCCB_MODE_WR3=2'b00.
- One sub-module, ov7670_config_rom: synchronous case-based ROM (address → 16-bit entry) holding the OV7670 register table. The first entry is 16'h1280 (COM7 soft reset), followed by a delay marker. Out-of-range addresses return CFG_END.

Test Plan:
- Boot + first write: small params (BOOT_WAIT=10, GAP=4). Behavioural SCCB model asserts busy 2 cycles after usher for 50 cycles → o_usher rises at cycle 10+3 after reset release, subaddress=8'h12, data=8'h80; usher falls the cycle after busy.
- Delay marker: table {1280, FFF0, 1104, FFFF} with DELAY_CYCLES=20 → second usher no earlier than 20 cycles after GAP ends; o_subaddress=8'h11, o_data=8'h04.
- End of table: after the last write completes → o_done=1, o_index=3, no further usher.
- Timeout: model never asserts busy, USHER_TIMEOUT=16 → o_usher high exactly 16 cycles, then o_error=1 with o_subaddress=8'h12 held. i_start → o_error clears and usher reappears for entry 0.
- Reset mid-write: assert i_reset during WAIT_BUSY_LO → next cycle o_usher=0, o_index=0, state BOOT_WAIT. Full table replays after reset release.
- Restart from DONE: pulse i_start → write sequence replays from entry 0 with no boot wait. i_start pulsed mid-sequence is ignored (index advances normally).
